avalon_st_pkt_fifo: RTL and testbench

// - Synchronous Avalon-ST packet FIFO. It sits directly upstream of the two-way

---
 rtl/avalon_st_pkt_fifo.sv | 87 ++++++++
 tb/tb_avalon_st_pkt_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_pkt_fifo.sv
// Avalon-ST packet FIFO, first-word fall-through, {sop, eop, data} stored as one word.
// Define AVST_PKT_FIFO_FILL_LEVEL_EN to add the fill_level and almost_full ports.
module avalon_st_pkt_fifo #(
    parameter int  INPUT_WIDTH = 32,
    parameter int  DEPTH       = 16,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clock_clk,
    input  logic                   reset_reset_n,
    input  logic [INPUT_WIDTH-1:0] asi_in0_data,
    input  logic                   asi_in0_valid,
    output logic                   asi_in0_ready,
    input  logic                   asi_in0_startofpacket,
    input  logic                   asi_in0_endofpacket,
    output logic [INPUT_WIDTH-1:0] aso_out0_data,
    output logic                   aso_out0_valid,
    input  logic                   aso_out0_ready,
    output logic                   aso_out0_startofpacket,
    output logic                   aso_out0_endofpacket
`ifdef AVST_PKT_FIFO_FILL_LEVEL_EN
    ,
    output logic [ADDR_W:0]        fill_level,
    output logic                   almost_full
`endif
);

    localparam int WORD_W = INPUT_WIDTH + 2;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic              empty, full;
    logic              wr_en, rd_en;
    logic [WORD_W-1:0] head_word;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                   (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);

    // Ready is a function of pointer state only; reset gates it off while asserted.
    assign asi_in0_ready  = reset_reset_n && !full;
    assign aso_out0_valid = !empty;

    assign wr_en = asi_in0_valid && asi_in0_ready;
    assign rd_en = aso_out0_valid && aso_out0_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage is never reset; the pointers alone decide what is valid.
    always_ff @(posedge clock_clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= {asi_in0_startofpacket, asi_in0_endofpacket, asi_in0_data};
        end
    end

    assign head_word              = mem[rd_ptr_reg[ADDR_W-1:0]];
    assign aso_out0_startofpacket = head_word[WORD_W-1];
    assign aso_out0_endofpacket   = head_word[WORD_W-2];
    assign aso_out0_data          = head_word[INPUT_WIDTH-1:0];

`ifdef AVST_PKT_FIFO_FILL_LEVEL_EN
    localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W + 1)'(DEPTH - 2);

    assign fill_level  = wr_ptr_reg - rd_ptr_reg;
    assign almost_full = (fill_level >= AF_THRESH);
`endif

endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// Directed self-checking bench for avalon_st_pkt_fifo (DEPTH=16, 32-bit data).
module tb_avalon_st_pkt_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid, in_ready, in_sop, in_eop;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_sop, out_eop;
`ifdef AVST_PKT_FIFO_FILL_LEVEL_EN
    logic [4:0]  fill_level;
    logic        almost_full;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avalon_st_pkt_fifo #(.INPUT_WIDTH(32), .DEPTH(16)) dut (
        .clock_clk              (clk),
        .reset_reset_n          (rst_n),
        .asi_in0_data           (in_data),
        .asi_in0_valid          (in_valid),
        .asi_in0_ready          (in_ready),
        .asi_in0_startofpacket  (in_sop),
        .asi_in0_endofpacket    (in_eop),
        .aso_out0_data          (out_data),
        .aso_out0_valid         (out_valid),
        .aso_out0_ready         (out_ready),
        .aso_out0_startofpacket (out_sop),
        .aso_out0_endofpacket   (out_eop)
`ifdef AVST_PKT_FIFO_FILL_LEVEL_EN
        ,
        .fill_level             (fill_level),
        .almost_full            (almost_full)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic e);
        in_valid = v;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
    endtask

    initial begin
        int rd_cnt;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef AVST_PKT_FIFO_FILL_LEVEL_EN
        chk("post_rst_fill", {27'd0, fill_level}, 32'd0);
        chk("post_rst_af", {31'd0, almost_full}, 32'd0);
`endif

        // Single word: visible only in the cycle after acceptance
        out_ready = 1'b1;
        drive(1'b1, 32'hA5A5_0001, 1'b1, 1'b1);
        #1;
        chk("single_no_bypass", {31'd0, out_valid}, 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_data", out_data, 32'hA5A5_0001);
        chk("single_sop", {31'd0, out_sop}, 32'd1);
        chk("single_eop", {31'd0, out_eop}, 32'd1);
        step();
        chk("single_gone", {31'd0, out_valid}, 32'd0);

        // Fill to full with words 0..15
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i), i == 0, i == 15);
            chk($sformatf("fill_ready_%0d", i), {31'd0, in_ready}, 32'd1);
            step();
`ifdef AVST_PKT_FIFO_FILL_LEVEL_EN
            chk($sformatf("fill_af_%0d", i), {31'd0, almost_full}, (i + 1 >= 14) ? 32'd1 : 32'd0);
`endif
        end
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_still_blocked", {31'd0, in_ready}, 32'd0);
        chk("full_head_data", out_data, 32'd0);
        chk("full_head_sop", {31'd0, out_sop}, 32'd1);
`ifdef AVST_PKT_FIFO_FILL_LEVEL_EN
        chk("full_fill", {27'd0, fill_level}, 32'd16);
        chk("full_af", {31'd0, almost_full}, 32'd1);
`endif

        // Drain 0..15 in order
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("drain_data_%0d", i), out_data, 32'(i));
            step();
            if (i == 0) chk("ready_after_read", {31'd0, in_ready}, 32'd1);
        end
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // 40 more words streamed through, crossing the pointer wrap
        rd_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
            if (out_valid) begin
                chk($sformatf("wrap_data_%0d", rd_cnt), out_data, 32'h100 + 32'(rd_cnt));
                rd_cnt++;
            end
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int t = 0; t < 4 && rd_cnt < 40; t++) begin
            if (out_valid) begin
                chk($sformatf("wrap_data_%0d", rd_cnt), out_data, 32'h100 + 32'(rd_cnt));
                rd_cnt++;
            end
            step();
        end
        chk("wrap_count", 32'(rd_cnt), 32'd40);
        chk("wrap_empty", {31'd0, out_valid}, 32'd0);

        // Level 8, then 10 cycles of simultaneous read and write
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h208 + 32'(k), 1'b0, 1'b0);
            chk($sformatf("rw_valid_%0d", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("rw_data_%0d", k), out_data, 32'h200 + 32'(k));
            step();
`ifdef AVST_PKT_FIFO_FILL_LEVEL_EN
            chk($sformatf("rw_fill_%0d", k), {27'd0, fill_level}, 32'd8);
`endif
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("rw_tail_%0d", j), out_data, 32'h20A + 32'(j));
            step();
        end
        chk("rw_empty", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a packet
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300 + 32'(i), i == 0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("mid_pkt_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_post_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_post_ready", {31'd0, in_ready}, 32'd1);
`ifdef AVST_PKT_FIFO_FILL_LEVEL_EN
        chk("mid_post_fill", {27'd0, fill_level}, 32'd0);
`endif
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h11, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        chk("new_pkt_data0", out_data, 32'h10);
        chk("new_pkt_sop0", {31'd0, out_sop}, 32'd1);
        chk("new_pkt_eop0", {31'd0, out_eop}, 32'd0);
        step();
        chk("new_pkt_data1", out_data, 32'h11);
        chk("new_pkt_sop1", {31'd0, out_sop}, 32'd0);
        chk("new_pkt_eop1", {31'd0, out_eop}, 32'd1);
        step();
        chk("new_pkt_done", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
